// File: rtl/key_sched.sv
// Multi-key debounce / long-press controller with a shared tick prescaler
// and a round-robin arbitrated valid/ready event port.
module key_sched #(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned DBNC_TICKS = 20,
  parameter int unsigned LONG_TICKS = 1000,
  localparam int unsigned ID_W      = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk50m,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_state,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_id,
  output logic [1:0]        evt_type,
  output logic              evt_drop
);

  localparam int unsigned TC_W   = $clog2(TICK_DIV);
  localparam int unsigned CNT_W  = $clog2(DBNC_TICKS + 1);
  localparam int unsigned LCNT_W = $clog2(LONG_TICKS + 1);

  localparam logic [TC_W-1:0]   TICK_LAST = TC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  DBNC_LAST = CNT_W'(DBNC_TICKS - 1);
  localparam logic [LCNT_W-1:0] LONG_LAST = LCNT_W'(LONG_TICKS - 1);
  localparam logic [LCNT_W-1:0] LONG_MAX  = LCNT_W'(LONG_TICKS);

  typedef enum logic [1:0] {S_REL, S_DB_HI, S_PRS, S_DB_LO} state_e;
  typedef enum logic [1:0] {EV_PRESS = 2'b00, EV_RELEASE = 2'b01, EV_LONG = 2'b10} evt_e;

  logic [N_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TC_W-1:0]   tc_q, tc_d;
  logic              tick;

  state_e            state_q [N_KEYS];
  state_e            state_d [N_KEYS];
  logic [CNT_W-1:0]  cnt_q   [N_KEYS];
  logic [CNT_W-1:0]  cnt_d   [N_KEYS];
  logic [LCNT_W-1:0] lcnt_q  [N_KEYS];
  logic [LCNT_W-1:0] lcnt_d  [N_KEYS];
  logic [N_KEYS-1:0] long_done_q, long_done_d;
  logic [N_KEYS-1:0] key_state_q, key_state_d;

  logic [N_KEYS-1:0] post;
  evt_e              post_t  [N_KEYS];

  logic [N_KEYS-1:0] slot_v_q, slot_v_d;
  evt_e              slot_t_q [N_KEYS];
  evt_e              slot_t_d [N_KEYS];
  logic              evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]   evt_id_q, evt_id_d;
  evt_e              evt_type_q, evt_type_d;
  logic              evt_drop_q, evt_drop_d;
  logic [ID_W-1:0]   rr_q, rr_d;

  logic              grant_ok;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  logic              drop_any;

  assign sync1_d = key;
  assign sync2_d = sync1_q;
  assign tick    = (tc_q == TICK_LAST);
  assign tc_d    = tick ? '0 : tc_q + 1'b1;

  // Per-key FSM; the synchronized level is checked before the tick.
  always_comb begin
    key_state_d = key_state_q;
    long_done_d = long_done_q;
    post        = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      lcnt_d[i]  = lcnt_q[i];
      post_t[i]  = EV_PRESS;
      case (state_q[i])
        S_REL: begin
          if (sync2_q[i]) begin
            state_d[i] = S_DB_HI;
            cnt_d[i]   = '0;
          end
        end
        S_DB_HI: begin
          if (!sync2_q[i]) begin
            state_d[i] = S_REL;
          end else if (tick) begin
            if (cnt_q[i] == DBNC_LAST) begin
              state_d[i]     = S_PRS;
              key_state_d[i] = 1'b1;
              post[i]        = 1'b1;
              post_t[i]      = EV_PRESS;
              lcnt_d[i]      = '0;
              long_done_d[i] = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        S_PRS: begin
          if (!sync2_q[i]) begin
            state_d[i] = S_DB_LO;
            cnt_d[i]   = '0;
          end else if (tick && (lcnt_q[i] != LONG_MAX)) begin
            lcnt_d[i] = lcnt_q[i] + 1'b1;
            if ((lcnt_q[i] == LONG_LAST) && !long_done_q[i]) begin
              post[i]        = 1'b1;
              post_t[i]      = EV_LONG;
              long_done_d[i] = 1'b1;
            end
          end
        end
        S_DB_LO: begin
          if (sync2_q[i]) begin
            state_d[i] = S_PRS;
          end else if (tick) begin
            if (cnt_q[i] == DBNC_LAST) begin
              state_d[i]     = S_REL;
              key_state_d[i] = 1'b0;
              post[i]        = 1'b1;
              post_t[i]      = EV_RELEASE;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        default: state_d[i] = S_REL;
      endcase
    end
  end

  // Grant clears its slot before new posts are stored, so a same-cycle
  // post into the granted slot is accepted rather than dropped.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned j = 1; j <= N_KEYS; j++) begin
      cand = ID_W'((32'(rr_q) + j) % N_KEYS);
      if (!grant_ok && slot_v_q[cand]) begin
        grant_ok  = 1'b1;
        grant_idx = cand;
      end
    end

    slot_v_d    = slot_v_q;
    slot_t_d    = slot_t_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_type_d  = evt_type_q;
    rr_d        = rr_q;
    if (!evt_valid_q || evt_ready) begin
      evt_valid_d = grant_ok;
      if (grant_ok) begin
        evt_id_d            = grant_idx;
        evt_type_d          = slot_t_q[grant_idx];
        slot_v_d[grant_idx] = 1'b0;
        rr_d                = grant_idx;
      end
    end

    drop_any = 1'b0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (post[i]) begin
        if (slot_v_d[i]) begin
          drop_any = 1'b1;
        end else begin
          slot_v_d[i] = 1'b1;
          slot_t_d[i] = post_t[i];
        end
      end
    end
    evt_drop_d = drop_any;
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      tc_q        <= '0;
      key_state_q <= '0;
      long_done_q <= '0;
      slot_v_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_type_q  <= EV_PRESS;
      evt_drop_q  <= 1'b0;
      rr_q        <= ID_W'(N_KEYS - 1);
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state_q[i]  <= S_REL;
        cnt_q[i]    <= '0;
        lcnt_q[i]   <= '0;
        slot_t_q[i] <= EV_PRESS;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tc_q        <= tc_d;
      key_state_q <= key_state_d;
      long_done_q <= long_done_d;
      slot_v_q    <= slot_v_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_type_q  <= evt_type_d;
      evt_drop_q  <= evt_drop_d;
      rr_q        <= rr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lcnt_q      <= lcnt_d;
      slot_t_q    <= slot_t_d;
    end
  end

  assign key_state = key_state_q;
  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_type  = evt_type_q;
  assign evt_drop  = evt_drop_q;

endmodule
